regfile_write_queue: RTL and testbench

Write-side front end for the CPU's 32×64-bit register file: buffers register writeback requests from the ALU and load paths in a small in-order queue and drains them one per cycle into the register file's single write port. It also provides a bypass lookup so decode sees values still pending in the queue. It sits between the EX/MEM result paths and the register file's `reg_write`/`write_register`/`write_data` inputs.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/wb_entry_fifo.sv | 82 ++++++++
 rtl/regfile_write_queue.sv | 114 +++++++++++
 tb/tb_regfile_write_queue.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register file write-side front end.
package regfile_pkg;

   localparam int DATA_WIDTH = 64;
   localparam int ADDR_WIDTH = 5;
   // XZR: architectural zero register, writes to it are dropped
   localparam int ZERO_REG   = 31;

   // One pending writeback: destination register and value
   typedef struct packed {
      logic [ADDR_WIDTH-1:0] rd;
      logic [DATA_WIDTH-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_entry_fifo.sv
// In-order storage for pending writebacks. Besides the head it exposes every
// slot rotated into age order (index 0 = oldest) so the owner can run a
// youngest-match search without knowing the pointer arithmetic.
module wb_entry_fifo
   import regfile_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    push,
   input  wb_entry_t               push_entry,
   input  logic                    pop,
   output wb_entry_t               head_entry,
   output wb_entry_t               age_entry [DEPTH],
   output logic [DEPTH-1:0]        age_valid,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    full,
   output logic                    empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   wb_entry_t     mem_q [DEPTH];
   wb_entry_t     mem_d [DEPTH];

   // Next-state: write at tail on push, advance head on pop; pointers wrap
   // naturally because DEPTH is a power of two.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      mem_d   = mem_q;
      if (push) begin
         mem_d[tail_q] = push_entry;
         tail_d        = tail_q + 1'b1;
      end
      if (pop) begin
         head_d = head_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // State registers; reset discards every entry
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         mem_q   <= mem_d;
      end
   end

   // Age-ordered view of the stored entries for the bypass search
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         age_entry[i] = mem_q[head_q + PW'(i)];
         age_valid[i] = (CW'(i) < count_q);
      end
   end

   assign head_entry = mem_q[head_q];
   assign count      = count_q;
   assign full       = (count_q == CW'(DEPTH));
   assign empty      = (count_q == '0);

endmodule

// File: rtl/regfile_write_queue.sv
// Write-side front end for the 32x64 register file: arbitrates ALU and load
// writebacks into an in-order queue, drains one entry per cycle into the
// single write port, and answers two bypass lookups against pending entries.
module regfile_write_queue
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
   parameter int DEPTH      = 4,
   parameter int ZERO_REG   = regfile_pkg::ZERO_REG
) (
   input  logic                    clock,
   input  logic                    reset_n,
   // ALU writeback request: transfer when alu_valid && alu_ready at the edge
   input  logic                    alu_valid,
   output logic                    alu_ready,
   input  logic [ADDR_WIDTH-1:0]   alu_rd,
   input  logic [DATA_WIDTH-1:0]   alu_data,
   // Load writeback request: same handshake, takes priority over the ALU
   input  logic                    mem_valid,
   output logic                    mem_ready,
   input  logic [ADDR_WIDTH-1:0]   mem_rd,
   input  logic [DATA_WIDTH-1:0]   mem_data,
   // Register file write port
   input  logic                    wb_stall,
   output logic                    reg_write,
   output logic [ADDR_WIDTH-1:0]   write_register,
   output logic [DATA_WIDTH-1:0]   write_data,
   // Bypass lookups for decode
   input  logic [ADDR_WIDTH-1:0]   lookup1,
   input  logic [ADDR_WIDTH-1:0]   lookup2,
   output logic                    hit1,
   output logic                    hit2,
   output logic [DATA_WIDTH-1:0]   hit_data1,
   output logic [DATA_WIDTH-1:0]   hit_data2,
   output logic [$clog2(DEPTH):0]  pending
);

   localparam logic [ADDR_WIDTH-1:0] XZR = ADDR_WIDTH'(ZERO_REG);

   logic       full;
   logic       empty;
   logic       mem_fire;
   logic       alu_fire;
   logic       push;
   wb_entry_t  push_entry;
   wb_entry_t  head_entry;
   wb_entry_t  age_entry [DEPTH];
   logic [DEPTH-1:0] age_valid;

   // Arbitration: ready depends only on registered fullness (never on
   // wb_stall), and an accepted XZR write completes the handshake but is
   // not stored.
   always_comb begin
      mem_ready  = !full;
      alu_ready  = !full && !mem_valid;
      mem_fire   = mem_valid && mem_ready;
      alu_fire   = alu_valid && alu_ready;
      push       = 1'b0;
      push_entry = '0;
      if (mem_fire) begin
         push_entry.rd   = mem_rd;
         push_entry.data = mem_data;
         push            = (mem_rd != XZR);
      end else if (alu_fire) begin
         push_entry.rd   = alu_rd;
         push_entry.data = alu_data;
         push            = (alu_rd != XZR);
      end
   end

   // Drain: present the head whenever something is queued, zeros otherwise
   always_comb begin
      reg_write      = !empty && !wb_stall;
      write_register = empty ? '0 : head_entry.rd;
      write_data     = empty ? '0 : head_entry.data;
   end

   // Bypass: scan oldest to youngest so the last match is the youngest one;
   // the in-flight request is not yet stored and so never matches.
   always_comb begin
      hit1      = 1'b0;
      hit2      = 1'b0;
      hit_data1 = '0;
      hit_data2 = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (age_valid[i] && (lookup1 != XZR) && (age_entry[i].rd == lookup1)) begin
            hit1      = 1'b1;
            hit_data1 = age_entry[i].data;
         end
         if (age_valid[i] && (lookup2 != XZR) && (age_entry[i].rd == lookup2)) begin
            hit2      = 1'b1;
            hit_data2 = age_entry[i].data;
         end
      end
   end

   wb_entry_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock      (clock),
      .reset_n    (reset_n),
      .push       (push),
      .push_entry (push_entry),
      .pop        (reg_write),
      .head_entry (head_entry),
      .age_entry  (age_entry),
      .age_valid  (age_valid),
      .count      (pending),
      .full       (full),
      .empty      (empty)
   );

endmodule

// File: tb/tb_regfile_write_queue.sv
// Bench for regfile_write_queue: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_regfile_write_queue;

   localparam int DW    = 64;
   localparam int AW    = 5;
   localparam int DEPTH = 4;
   localparam logic [AW-1:0] ZR = 5'd31;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset_n;
   always #5 clock = ~clock;

   logic          alu_valid, mem_valid, wb_stall;
   logic          alu_ready, mem_ready;
   logic [AW-1:0] alu_rd, mem_rd, lookup1, lookup2;
   logic [DW-1:0] alu_data, mem_data;
   logic          reg_write, hit1, hit2;
   logic [AW-1:0] write_register;
   logic [DW-1:0] write_data, hit_data1, hit_data2;
   logic [2:0]    pending;

   regfile_write_queue dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .alu_valid      (alu_valid),
      .alu_ready      (alu_ready),
      .alu_rd         (alu_rd),
      .alu_data       (alu_data),
      .mem_valid      (mem_valid),
      .mem_ready      (mem_ready),
      .mem_rd         (mem_rd),
      .mem_data       (mem_data),
      .wb_stall       (wb_stall),
      .reg_write      (reg_write),
      .write_register (write_register),
      .write_data     (write_data),
      .lookup1        (lookup1),
      .lookup2        (lookup2),
      .hit1           (hit1),
      .hit2           (hit2),
      .hit_data1      (hit_data1),
      .hit_data2      (hit_data2),
      .pending        (pending)
   );

   // ---------------- scoreboard / reference model ----------------
   // Each element is {rd, data}; index 0 is the oldest pending write.
   logic [AW+DW-1:0] exp_q[$];
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Youngest stored entry for a given register; XZR never matches
   function automatic void ref_lookup(input logic [AW-1:0] l, output logic h,
                                      output logic [DW-1:0] d);
      h = 1'b0;
      d = '0;
      if (l != ZR) begin
         for (int j = exp_q.size() - 1; j >= 0; j--) begin
            if (exp_q[j][DW +: AW] == l) begin
               h = 1'b1;
               d = exp_q[j][DW-1:0];
               break;
            end
         end
      end
   endfunction

   // Compare every output with what the model says it should be right now
   task automatic check_outputs();
      logic          full;
      logic          eh;
      logic [DW-1:0] ed;
      full = (exp_q.size() == DEPTH);
      check("mem_ready", {63'd0, mem_ready}, {63'd0, !full});
      check("alu_ready", {63'd0, alu_ready}, {63'd0, !full && !mem_valid});
      check("reg_write", {63'd0, reg_write}, {63'd0, (exp_q.size() != 0) && !wb_stall});
      if (exp_q.size() != 0) begin
         check("write_register", 64'(write_register), 64'(exp_q[0][DW +: AW]));
         check("write_data", write_data, exp_q[0][DW-1:0]);
      end else begin
         check("write_register_idle", 64'(write_register), 64'd0);
         check("write_data_idle", write_data, 64'd0);
      end
      check("pending", 64'(pending), 64'(exp_q.size()));
      ref_lookup(lookup1, eh, ed);
      check("hit1", {63'd0, hit1}, {63'd0, eh});
      check("hit_data1", hit_data1, ed);
      ref_lookup(lookup2, eh, ed);
      check("hit2", {63'd0, hit2}, {63'd0, eh});
      check("hit_data2", hit_data2, ed);
   endtask

   // Apply the queue rules for one rising edge using the pre-edge inputs
   task automatic model_update();
      logic full;
      logic pop;
      full = (exp_q.size() == DEPTH);
      pop  = (exp_q.size() != 0) && !wb_stall;
      if (pop) void'(exp_q.pop_front());
      if (!full) begin
         if (mem_valid) begin
            if (mem_rd != ZR) exp_q.push_back({mem_rd, mem_data});
         end else if (alu_valid) begin
            if (alu_rd != ZR) exp_q.push_back({alu_rd, alu_data});
         end
      end
   endtask

   // One clock: check at the falling edge, update model at the rising edge
   task automatic cycle();
      @(negedge clock);
      check_outputs();
      @(posedge clock);
      if (!reset_n) exp_q.delete();
      else model_update();
      #1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_idle();
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
   endtask

   task automatic drive_alu(input logic [AW-1:0] rd, input logic [DW-1:0] d);
      alu_valid = 1'b1; alu_rd = rd; alu_data = d;
   endtask

   task automatic drive_mem(input logic [AW-1:0] rd, input logic [DW-1:0] d);
      mem_valid = 1'b1; mem_rd = rd; mem_data = d;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset_n = 1'b0;
      drive_idle();
      wb_stall = 1'b0;
      lookup1 = 5'd3;
      lookup2 = 5'd4;
      #12;
      check("rst_reg_write", {63'd0, reg_write}, 64'd0);
      check("rst_write_register", 64'(write_register), 64'd0);
      check("rst_write_data", write_data, 64'd0);
      check("rst_pending", 64'(pending), 64'd0);
      check("rst_mem_ready", {63'd0, mem_ready}, 64'd1);
      check("rst_alu_ready", {63'd0, alu_ready}, 64'd1);
      check("rst_hit1", {63'd0, hit1}, 64'd0);
      check("rst_hit_data2", hit_data2, 64'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;

      // Single ALU write reaches the port one cycle later
      drive_alu(5'd3, 64'hAA);
      cycle();
      drive_idle();
      check("t1_reg_write", {63'd0, reg_write}, 64'd1);
      check("t1_write_register", 64'(write_register), 64'd3);
      check("t1_write_data", write_data, 64'hAA);
      cycle();
      check("t1_pending", 64'(pending), 64'd0);

      // Load beats ALU in the same cycle
      drive_mem(5'd5, 64'h55_0000);
      drive_alu(5'd4, 64'h44_0000);
      #1;
      check("t2_alu_ready", {63'd0, alu_ready}, 64'd0);
      check("t2_mem_ready", {63'd0, mem_ready}, 64'd1);
      cycle();
      mem_valid = 1'b0;
      check("t2_first", 64'(write_register), 64'd5);
      cycle();
      drive_idle();
      check("t2_second", 64'(write_register), 64'd4);
      cycle();
      cycle();

      // Fill under stall, bypass sees youngest, drain in order on release
      wb_stall = 1'b1;
      lookup1  = 5'd7;
      for (int k = 1; k <= 4; k++) begin
         drive_alu(5'd7, 64'(k));
         cycle();
      end
      drive_alu(5'd7, 64'd5);
      #1;
      check("t3_pending", 64'(pending), 64'd4);
      check("t3_alu_ready", {63'd0, alu_ready}, 64'd0);
      check("t3_hit1", {63'd0, hit1}, 64'd1);
      check("t3_hit_data1", hit_data1, 64'd4);
      cycle();
      drive_idle();
      wb_stall = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         #1;
         check("t3_drain", write_data, 64'(k));
         cycle();
      end

      // XZR write: handshake completes, nothing stored
      lookup1 = ZR;
      drive_alu(ZR, 64'h55);
      #1;
      check("t4_alu_ready", {63'd0, alu_ready}, 64'd1);
      cycle();
      drive_idle();
      check("t4_pending", 64'(pending), 64'd0);
      check("t4_reg_write", {63'd0, reg_write}, 64'd0);
      check("t4_hit1", {63'd0, hit1}, 64'd0);
      cycle();

      // Sustained throughput across pointer wrap
      for (int k = 0; k < 10; k++) begin
         drive_alu(AW'($urandom_range(0, 30)), {$urandom, $urandom});
         lookup1 = alu_rd;
         cycle();
         check("t5_pending", 64'(pending), 64'd1);
      end
      drive_idle();
      cycle();

      // Reset with three entries pending
      wb_stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         drive_alu(AW'(10 + k), 64'(100 + k));
         cycle();
      end
      drive_idle();
      mem_valid = 1'b1;
      mem_rd    = 5'd12;
      lookup1   = 5'd11;
      #1;
      reset_n = 1'b0;
      exp_q.delete();
      #1;
      check("t6_pending", 64'(pending), 64'd0);
      check("t6_write_register", 64'(write_register), 64'd0);
      check("t6_write_data", write_data, 64'd0);
      check("t6_hit1", {63'd0, hit1}, 64'd0);
      check("t6_mem_ready", {63'd0, mem_ready}, 64'd1);
      check("t6_alu_ready", {63'd0, alu_ready}, 64'd0);
      wb_stall = 1'b0;
      cycle();
      cycle();
      mem_valid = 1'b0;
      #2;
      reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cycle();
         check("t6_no_write", {63'd0, reg_write}, 64'd0);
      end

      // Random traffic against the model
      for (int k = 0; k < 400; k++) begin
         drive_idle();
         if ($urandom_range(0, 99) < 40) drive_mem(AW'($urandom_range(0, 31)), {$urandom, $urandom});
         if ($urandom_range(0, 99) < 60) drive_alu(AW'($urandom_range(0, 31)), {$urandom, $urandom});
         if ($urandom_range(0, 7) == 0) begin
            if (mem_valid) mem_rd = ZR;
            else alu_rd = ZR;
         end
         wb_stall = ($urandom_range(0, 99) < 35);
         lookup1  = AW'($urandom_range(0, 31));
         lookup2  = ($urandom_range(0, 1) == 0) ? ZR : AW'($urandom_range(0, 7));
         cycle();
      end
      drive_idle();
      wb_stall = 1'b0;
      for (int k = 0; k < 6; k++) cycle();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
